rv32i_issue_ctrl: RTL

- Issue/hazard controller between the rv32i decode stage and execute.
- Keeps a per-register pending-write scoreboard and stalls decode on RAW and WAW hazards.
- Serialises SYSTEM (opcode 0x73) instructions.
- Sequences the fetch/decode flush after a taken branch or jump redirect from execute.
- Decode registers its pipe word only on cycles where issue_o is high.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rv32i_scoreboard.sv | 52 +++++
 rtl/rv32i_issue_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: opcodes, issue-controller states and register-number type.
package rv32i_pkg;

  localparam int RF_REGS   = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } issue_state_e;

  typedef logic [RF_ADDR_W-1:0] reg_num_t;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Pending-write scoreboard: writeback clears first, issue sets second, x0 never pending.
module rv32i_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_num_i,
  input  logic                  set_valid_i,
  input  logic [REG_ADDR_W-1:0] set_num_i,
  input  logic [REG_ADDR_W-1:0] rs1_num_i,
  input  logic [REG_ADDR_W-1:0] rs2_num_i,
  input  logic [REG_ADDR_W-1:0] rd_num_i,
  output logic                  rs1_pend_o,
  output logic                  rs2_pend_o,
  output logic                  rd_pend_o,
  output logic                  any_pend_o,
  output logic                  any_next_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask, eff;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mask
    if (gi == 0) begin : g_x0
      assign clr_mask[gi] = 1'b0;
      assign set_mask[gi] = 1'b0;
    end else begin : g_xn
      assign clr_mask[gi] = clr_valid_i & (clr_num_i == REG_ADDR_W'(gi));
      assign set_mask[gi] = set_valid_i & (set_num_i == REG_ADDR_W'(gi));
    end
  end

  // Same-cycle writeback is visible to lookups (write-through register file).
  assign eff       = pending_q & ~clr_mask;
  assign pending_d = eff | set_mask;

  assign rs1_pend_o = eff[rs1_num_i];
  assign rs2_pend_o = eff[rs2_num_i];
  assign rd_pend_o  = eff[rd_num_i];
  assign any_pend_o = |eff;
  assign any_next_o = |pending_d;
  assign pending_o  = pending_q;

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/rv32i_issue_ctrl.sv
// Decode-to-execute issue control: RAW/WAW stalls, SYSTEM serialisation and redirect flush.
module rv32i_issue_ctrl
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid_i,
  input  logic [6:0]            dec_opcode_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_num_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_num_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_num_i,
  output logic                  issue_o,
  output logic                  stall_o,
  output logic                  flush_o,
  input  logic                  redirect_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_num_i,
  output logic [NUM_REGS-1:0]   pending_o
);

  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  issue_state_e state_q, state_d;
  logic [3:0]   flush_cnt_q, flush_cnt_d;
  logic         ret_drain_q, ret_drain_d;

  logic rs1_pend, rs2_pend, rd_pend, any_pend, any_next;
  logic hazard, is_sys, sys_ok;

  rv32i_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clr_valid_i(wb_valid_i),
    .clr_num_i  (wb_rd_num_i),
    .set_valid_i(issue_o),
    .set_num_i  (dec_rd_num_i),
    .rs1_num_i  (dec_rs1_num_i),
    .rs2_num_i  (dec_rs2_num_i),
    .rd_num_i   (dec_rd_num_i),
    .rs1_pend_o (rs1_pend),
    .rs2_pend_o (rs2_pend),
    .rd_pend_o  (rd_pend),
    .any_pend_o (any_pend),
    .any_next_o (any_next),
    .pending_o  (pending_o)
  );

  assign is_sys  = (dec_opcode_i == OPC_SYSTEM);
  assign hazard  = rs1_pend | rs2_pend | rd_pend;
  assign sys_ok  = ~is_sys | ~any_pend;
  assign issue_o = dec_valid_i & (state_q == RUN) & ~hazard & ~redirect_i & sys_ok;
  assign flush_o = redirect_i | (state_q == FLUSH);
  assign stall_o = dec_valid_i & ~issue_o & ~flush_o;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ret_drain_d = ret_drain_q;
    if (redirect_i) begin
      // A single-cycle flush is covered by redirect_i alone, so the state is kept.
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
        ret_drain_d = (state_q == DRAIN) | (ret_drain_q & (state_q == FLUSH));
      end
    end else begin
      case (state_q)
        RUN: begin
          if (issue_o && is_sys) state_d = DRAIN;
        end
        DRAIN: begin
          if (!any_next) state_d = RUN;
        end
        FLUSH: begin
          if (flush_cnt_q != 4'd0) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end else begin
            state_d     = (ret_drain_q && any_next) ? DRAIN : RUN;
            ret_drain_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 4'd0;
      ret_drain_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ret_drain_q <= ret_drain_d;
    end
  end

endmodule
